// File: rtl/interconnect_pkg.sv
// interconnect_pkg: shared timestamp default width and wrap-safe due test
package interconnect_pkg;
  localparam int TS_W_DEF = 16;
  function automatic logic ts_due(input logic [31:0] now, input logic [31:0] due, input int w);
    logic [31:0] d;
    d = (now - due) >> (w - 1);
    return !d[0];
  endfunction
endpackage

// File: rtl/link_delay_lane.sv
// link_delay_lane: one lane-direction FIFO with due-time release, gap throttle and occupancy
module link_delay_lane
  import interconnect_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 1,
  parameter int GAP     = 1,
  parameter int TS_W    = TS_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TS_W-1:0]  now,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  logic [TS_W+WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [GW-1:0] gap;
  logic [TS_W-1:0] stamp;
  logic head_due, due_now, push, pop;
  always_comb begin
    {stamp, out_data} = mem[rp];
    due_now = ts_due(32'(now), 32'(stamp), TS_W);
    in_ready = cnt != (AW+1)'(DEPTH);
    busy = cnt != '0;
    out_valid = busy && (head_due || due_now) && gap == '0;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {now + TS_W'(LATENCY), in_data};
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      gap <= '0;
      head_due <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      gap <= pop ? GW'(GAP - 1) : gap - GW'(gap != '0);
      head_due <= !pop && (head_due || (busy && due_now));
    end
endmodule

// File: rtl/interconnect_link_model.sv
// interconnect_link_model: bidirectional multi-lane inter-FPGA link with latency, throttle and side-band delay
module interconnect_link_model
  import interconnect_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int CHANNELS = 4,
  parameter int LATENCY  = 1,
  parameter int DEPTH    = 128,
  parameter int GAP      = 1,
  parameter int TS_W     = TS_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] upstream_fifo_in_data,
  input  logic [CHANNELS-1:0]       upstream_fifo_in_valid,
  output logic [CHANNELS-1:0]       upstream_fifo_in_ready,
  output logic [WIDTH*CHANNELS-1:0] downstream_fifo_out_data,
  output logic [CHANNELS-1:0]       downstream_fifo_out_valid,
  input  logic [CHANNELS-1:0]       downstream_fifo_out_ready,
  input  logic [WIDTH*CHANNELS-1:0] downstream_fifo_in_data,
  input  logic [CHANNELS-1:0]       downstream_fifo_in_valid,
  output logic [CHANNELS-1:0]       downstream_fifo_in_ready,
  output logic [WIDTH*CHANNELS-1:0] upstream_fifo_out_data,
  output logic [CHANNELS-1:0]       upstream_fifo_out_valid,
  input  logic [CHANNELS-1:0]       upstream_fifo_out_ready,
  input  logic [CHANNELS-1:0]       downstream_has_message_flying,
  input  logic [CHANNELS-1:0]       downstream_has_odd_clusters,
  output logic [CHANNELS-1:0]       upstream_has_message_flying,
  output logic [CHANNELS-1:0]       upstream_has_odd_clusters,
  input  logic [2*CHANNELS-1:0]     upstream_state_signal,
  output logic [2*CHANNELS-1:0]     downstream_state_signal,
  output logic [CHANNELS-1:0]       link_busy
);
  localparam int SBW = 4 * CHANNELS;
  if (LATENCY >= 2 ** (TS_W - 1)) begin : g_bad_lat
    $error("LATENCY must be below 2**(TS_W-1)");
  end
  if (LATENCY == 0 && GAP != 1) begin : g_bad_gap
    $error("GAP must be 1 when LATENCY is 0");
  end
  if (LATENCY == 0) begin : g_wire
    assign downstream_fifo_out_data = upstream_fifo_in_data;
    assign downstream_fifo_out_valid = upstream_fifo_in_valid;
    assign upstream_fifo_in_ready = downstream_fifo_out_ready;
    assign upstream_fifo_out_data = downstream_fifo_in_data;
    assign upstream_fifo_out_valid = downstream_fifo_in_valid;
    assign downstream_fifo_in_ready = upstream_fifo_out_ready;
    assign upstream_has_message_flying = downstream_has_message_flying;
    assign upstream_has_odd_clusters = downstream_has_odd_clusters;
    assign downstream_state_signal = upstream_state_signal;
    assign link_busy = '0;
  end else begin : g_link
    logic [TS_W-1:0] now;
    logic [CHANNELS-1:0] busy_dn, busy_up;
    logic [SBW-1:0] sr [LATENCY];
    always_ff @(posedge clk)
      now <= reset ? '0 : now + 1'b1;
    always_ff @(posedge clk)
      if (reset) sr <= '{default: '0};
      else begin
        sr[0] <= {downstream_has_message_flying, downstream_has_odd_clusters, upstream_state_signal};
        for (int k = 1; k < LATENCY; k++) sr[k] <= sr[k-1];
      end
    assign {upstream_has_message_flying, upstream_has_odd_clusters, downstream_state_signal} = sr[LATENCY-1];
    assign link_busy = busy_dn | busy_up;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      link_delay_lane #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY), .GAP(GAP), .TS_W(TS_W)
      ) u_dn (
        .clk(clk),
        .reset(reset),
        .now(now),
        .in_data(upstream_fifo_in_data[c*WIDTH +: WIDTH]),
        .in_valid(upstream_fifo_in_valid[c]),
        .in_ready(upstream_fifo_in_ready[c]),
        .out_data(downstream_fifo_out_data[c*WIDTH +: WIDTH]),
        .out_valid(downstream_fifo_out_valid[c]),
        .out_ready(downstream_fifo_out_ready[c]),
        .busy(busy_dn[c])
      );
      link_delay_lane #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY), .GAP(GAP), .TS_W(TS_W)
      ) u_up (
        .clk(clk),
        .reset(reset),
        .now(now),
        .in_data(downstream_fifo_in_data[c*WIDTH +: WIDTH]),
        .in_valid(downstream_fifo_in_valid[c]),
        .in_ready(downstream_fifo_in_ready[c]),
        .out_data(upstream_fifo_out_data[c*WIDTH +: WIDTH]),
        .out_valid(upstream_fifo_out_valid[c]),
        .out_ready(upstream_fifo_out_ready[c]),
        .busy(busy_up[c])
      );
    end
  end
endmodule

// File: tb/tb_interconnect_link_model.sv
// tb_interconnect_link_model: directed self-checking bench for latency, throttle, depth, wrap, side-band and reset
module tb_interconnect_link_model;
  localparam int W = 8;
  localparam int CA = 4;
  localparam int CB = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  logic [CA*W-1:0] a_ui_d, a_do_d, a_di_d, a_uo_d;
  logic [CA-1:0] a_ui_v, a_ui_r, a_do_v, a_do_r, a_di_v, a_di_r, a_uo_v, a_uo_r;
  logic [CA-1:0] a_dfly, a_dodd, a_ufly, a_uodd, a_busy;
  logic [2*CA-1:0] a_ust, a_dst;
  logic [CB*W-1:0] b_ui_d, b_do_d, b_di_d, b_uo_d;
  logic [CB-1:0] b_ui_v, b_ui_r, b_do_v, b_do_r, b_di_v, b_di_r, b_uo_v, b_uo_r;
  logic [CB-1:0] b_dfly, b_dodd, b_ufly, b_uodd, b_busy;
  logic [2*CB-1:0] b_ust, b_dst;
  interconnect_link_model #(
    .WIDTH(W), .CHANNELS(CA), .LATENCY(3), .DEPTH(8), .GAP(4), .TS_W(8)
  ) dut_a (
    .clk(clk), .reset(reset),
    .upstream_fifo_in_data(a_ui_d), .upstream_fifo_in_valid(a_ui_v), .upstream_fifo_in_ready(a_ui_r),
    .downstream_fifo_out_data(a_do_d), .downstream_fifo_out_valid(a_do_v), .downstream_fifo_out_ready(a_do_r),
    .downstream_fifo_in_data(a_di_d), .downstream_fifo_in_valid(a_di_v), .downstream_fifo_in_ready(a_di_r),
    .upstream_fifo_out_data(a_uo_d), .upstream_fifo_out_valid(a_uo_v), .upstream_fifo_out_ready(a_uo_r),
    .downstream_has_message_flying(a_dfly), .downstream_has_odd_clusters(a_dodd),
    .upstream_has_message_flying(a_ufly), .upstream_has_odd_clusters(a_uodd),
    .upstream_state_signal(a_ust), .downstream_state_signal(a_dst), .link_busy(a_busy)
  );
  interconnect_link_model #(
    .WIDTH(W), .CHANNELS(CB), .LATENCY(2), .DEPTH(4), .GAP(1), .TS_W(16)
  ) dut_b (
    .clk(clk), .reset(reset),
    .upstream_fifo_in_data(b_ui_d), .upstream_fifo_in_valid(b_ui_v), .upstream_fifo_in_ready(b_ui_r),
    .downstream_fifo_out_data(b_do_d), .downstream_fifo_out_valid(b_do_v), .downstream_fifo_out_ready(b_do_r),
    .downstream_fifo_in_data(b_di_d), .downstream_fifo_in_valid(b_di_v), .downstream_fifo_in_ready(b_di_r),
    .upstream_fifo_out_data(b_uo_d), .upstream_fifo_out_valid(b_uo_v), .upstream_fifo_out_ready(b_uo_r),
    .downstream_has_message_flying(b_dfly), .downstream_has_odd_clusters(b_dodd),
    .upstream_has_message_flying(b_ufly), .upstream_has_odd_clusters(b_uodd),
    .upstream_state_signal(b_ust), .downstream_state_signal(b_dst), .link_busy(b_busy)
  );
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_do_v, a_uo_v, a_busy, a_ufly, a_uodd, a_dst} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs got %h want 0", {a_do_v, a_uo_v, a_busy, a_ufly, a_uodd, a_dst});
    end
    checks++;
    if ({a_ui_r, a_di_r} !== '1) begin
      errors++;
      $display("FAIL reset_a_ready got %b want all ones", {a_ui_r, a_di_r});
    end
    checks++;
    if ({b_do_v, b_uo_v, b_busy, b_ufly, b_uodd, b_dst, ~b_ui_r, ~b_di_r} !== '0) begin
      errors++;
      $display("FAIL reset_b_state got %h want 0", {b_do_v, b_uo_v, b_busy, b_ufly, b_uodd, b_dst, ~b_ui_r, ~b_di_r});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_latency();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (a_do_v[0] !== (i == 3)) begin
        errors++;
        $display("FAIL lat_valid i=%0d got %b want %b", i, a_do_v[0], i == 3);
      end
      if (i == 3) begin
        checks++;
        if (a_do_d[7:0] !== 8'hA5) begin
          errors++;
          $display("FAIL lat_data got %h want a5", a_do_d[7:0]);
        end
      end
      if (i == 0) begin
        checks++;
        if (a_ui_r[0] !== 1'b1) begin
          errors++;
          $display("FAIL lat_ready got %b want 1", a_ui_r[0]);
        end
      end
      a_ui_v[0] = i == 0;
      a_ui_d[7:0] = 8'hA5;
      @(negedge clk);
    end
  endtask
  task automatic test_gap();
    logic ev;
    for (int i = 0; i < 24; i++) begin
      ev = i >= 3 && (i - 3) % 4 == 0 && (i - 3) / 4 < 5;
      checks++;
      if (a_do_v[1] !== ev) begin
        errors++;
        $display("FAIL gap_valid i=%0d got %b want %b", i, a_do_v[1], ev);
      end
      if (ev) begin
        checks++;
        if (a_do_d[15:8] !== 8'(16 + (i - 3) / 4)) begin
          errors++;
          $display("FAIL gap_data i=%0d got %h want %h", i, a_do_d[15:8], 8'(16 + (i - 3) / 4));
        end
      end
      a_ui_v[1] = i < 5;
      a_ui_d[15:8] = 8'(16 + i);
      @(negedge clk);
    end
  endtask
  task automatic test_full();
    int n = 0;
    a_do_r[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_ui_r[2] !== (i < 8)) begin
        errors++;
        $display("FAIL full_ready i=%0d got %b want %b", i, a_ui_r[2], i < 8);
      end
      a_ui_v[2] = i < 9;
      a_ui_d[23:16] = 8'(32 + i);
      @(negedge clk);
    end
    checks++;
    if ({a_busy[2], a_do_v[2]} !== 2'b11) begin
      errors++;
      $display("FAIL full_busy_valid got %b want 11", {a_busy[2], a_do_v[2]});
    end
    a_do_r[2] = 1'b1;
    for (int i = 0; i < 41; i++) begin
      if (a_do_v[2]) begin
        checks++;
        if (a_do_d[23:16] !== 8'(32 + n)) begin
          errors++;
          $display("FAIL full_order n=%0d got %h want %h", n, a_do_d[23:16], 8'(32 + n));
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL full_count got %0d want 8", n);
    end
    checks++;
    if ({a_busy[2], a_ui_r[2]} !== 2'b01) begin
      errors++;
      $display("FAIL full_drain got busy,ready=%b want 01", {a_busy[2], a_ui_r[2]});
    end
  endtask
  task automatic test_hold();
    int bad = 0;
    int extra = 0;
    a_do_r[3] = 1'b0;
    for (int i = 0; i < 303; i++) begin
      if (i >= 3 && (a_do_v[3] !== 1'b1 || a_do_d[31:24] !== 8'h5C)) bad++;
      if (i < 3 && a_do_v[3] !== 1'b0) bad++;
      a_ui_v[3] = i == 0;
      a_ui_d[31:24] = 8'h5C;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable got %0d bad cycles want 0", bad);
    end
    checks++;
    if ({a_do_v[3], a_do_d[31:24]} !== {1'b1, 8'h5C}) begin
      errors++;
      $display("FAIL hold_head got %b/%h want 1/5c", a_do_v[3], a_do_d[31:24]);
    end
    a_do_r[3] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (a_do_v[3]) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra !== 0 || a_busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL hold_once got extra=%0d busy=%b want 0 0", extra, a_busy[3]);
    end
  endtask
  task automatic test_side_band();
    logic [7:0] ex;
    for (int i = 0; i < 8; i++) begin
      ex = (i >= 2 && i < 5) ? 8'b01_10_1100 : 8'h00;
      checks++;
      if ({b_ufly, b_uodd, b_dst} !== ex) begin
        errors++;
        $display("FAIL side_band i=%0d got %b want %b", i, {b_ufly, b_uodd, b_dst}, ex);
      end
      b_dfly = i < 3 ? 2'b01 : 2'b00;
      b_dodd = i < 3 ? 2'b10 : 2'b00;
      b_ust = i < 3 ? 4'b1100 : 4'b0000;
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    logic ev;
    for (int i = 0; i < 8; i++) begin
      ev = i >= 2 && i <= 4;
      checks++;
      if (b_uo_v[0] !== ev || (ev && b_uo_d[7:0] !== 8'(49 + i - 2))) begin
        errors++;
        $display("FAIL b2b i=%0d got %b/%h want %b/%h", i, b_uo_v[0], b_uo_d[7:0], ev, 8'(49 + i - 2));
      end
      b_di_v[0] = i < 3;
      b_di_d[7:0] = 8'(49 + i);
      @(negedge clk);
    end
  endtask
  task automatic test_reset_flight();
    a_do_r[0] = 1'b0;
    a_do_r[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_ui_v[0] = i < 3;
      a_ui_v[2] = i < 3;
      a_ui_d[7:0] = 8'(64 + i);
      a_ui_d[23:16] = 8'(80 + i);
      a_dfly = '1;
      @(negedge clk);
    end
    checks++;
    if ({a_busy, a_ufly, a_do_v[0], a_do_v[2]} !== {4'b0101, 4'b1111, 2'b11}) begin
      errors++;
      $display("FAIL flight_pre got %b want 0101111111", {a_busy, a_ufly, a_do_v[0], a_do_v[2]});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_do_v, a_uo_v, a_busy, a_ufly, a_uodd, a_dst} !== '0) begin
      errors++;
      $display("FAIL flight_reset got %h want 0", {a_do_v, a_uo_v, a_busy, a_ufly, a_uodd, a_dst});
    end
    checks++;
    if ({a_ui_r, a_di_r} !== '1) begin
      errors++;
      $display("FAIL flight_ready got %b want all ones", {a_ui_r, a_di_r});
    end
    reset = 1'b0;
    a_dfly = '0;
    a_do_r = '1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (a_do_v[0] !== (i == 3) || (i == 3 && a_do_d[7:0] !== 8'h77)) begin
        errors++;
        $display("FAIL flight_post i=%0d got %b/%h want %b/77", i, a_do_v[0], a_do_d[7:0], i == 3);
      end
      a_ui_v[0] = i == 0;
      a_ui_d[7:0] = 8'h77;
      @(negedge clk);
    end
  endtask
  initial begin
    a_ui_d = '0; a_ui_v = '0; a_do_r = '1; a_di_d = '0; a_di_v = '0; a_uo_r = '1;
    a_dfly = '0; a_dodd = '0; a_ust = '0;
    b_ui_d = '0; b_ui_v = '0; b_do_r = '1; b_di_d = '0; b_di_v = '0; b_uo_r = '1;
    b_dfly = '0; b_dodd = '0; b_ust = '0;
    test_reset();
    test_latency();
    test_gap();
    test_full();
    test_hold();
    test_side_band();
    test_back_to_back();
    test_reset_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
